// File: rtl/sqrt_magnitude_feeder.sv
// Purpose: squares a signed (x,y) pair with a bit-serial shift-add multiplier and feeds x*x+y*y to the root unit.
// Latency: accept + 32 MUL + 1 entry + root latency + release + 1 OUT cycles (33 total for a zero sum).
// Backpressure: in_ready only in IDLE; the result is held on out_valid until out_ready.
module sqrt_magnitude_feeder #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_mag,
    output logic        out_err,
    output logic        sq_start,
    output logic [31:0] sq_in,
    input  logic        sq_done,
    input  logic        sq_available,
    input  logic [31:0] sq_out,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_WAIT,
        S_REQ,
        S_REL,
        S_ZERO,
        S_OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   abs_x;
    logic [15:0]   abs_y;
    logic [4:0]    mul_cnt;
    logic [31:0]   acc;
    logic [31:0]   acc_nxt;
    logic [15:0]   mul_op;
    logic [31:0]   partial;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          armed;
    logic [31:0]   mag;
    logic          err;

    // One multiplier bit per cycle: first 16 cycles square |x|, last 16 square |y|
    always_comb begin
        mul_op  = mul_cnt[4] ? abs_y : abs_x;
        partial = 32'd0;
        if (mul_op[mul_cnt[3:0]]) begin
            partial = {16'd0, mul_op} << mul_cnt[3:0];
        end
        acc_nxt = acc + partial;
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign sq_in   = acc;
    assign out_mag = mag;
    assign out_err = err;

    // State register; reset overrides everything, including an in-flight request
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sq_start  = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                // armed keeps in_ready low during the reset cycle itself
                in_ready = armed;
                if (in_valid && armed) state_nxt = S_MUL;
            end
            S_MUL: begin
                if (mul_cnt == 5'd31) state_nxt = (acc_nxt == 32'd0) ? S_ZERO : S_WAIT;
            end
            S_WAIT: begin
                if (sq_available && !sq_done) state_nxt = S_REQ;
            end
            S_REQ: begin
                sq_start = 1'b1;
                if (sq_done || tmo_hit) state_nxt = S_REL;
            end
            S_REL: begin
                // root unit clears DONE only after it has seen START low
                if (!sq_done && sq_available) state_nxt = S_OUT;
            end
            S_ZERO: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulation, timeout count and result capture
    always_ff @(posedge clk) begin
        if (rstn) begin
            abs_x   <= 16'd0;
            abs_y   <= 16'd0;
            mul_cnt <= 5'd0;
            acc     <= 32'd0;
            tmo_cnt <= '0;
            mag     <= 32'd0;
            err     <= 1'b0;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid && armed) begin
                        // two's-complement negate; -32768 maps to 32768 unsigned
                        abs_x   <= in_x[15] ? (~in_x + 16'd1) : in_x;
                        abs_y   <= in_y[15] ? (~in_y + 16'd1) : in_y;
                        acc     <= 32'd0;
                        mul_cnt <= 5'd0;
                    end
                end
                S_MUL: begin
                    acc     <= acc_nxt;
                    mul_cnt <= mul_cnt + 5'd1;
                end
                S_WAIT: begin
                    tmo_cnt <= '0;
                end
                S_REQ: begin
                    if (sq_done) begin
                        mag <= sq_out;
                        err <= 1'b0;
                    end else if (tmo_hit) begin
                        mag <= 32'd0;
                        err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_ZERO: begin
                    mag <= 32'd0;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_magnitude_feeder.sv
// Purpose: directed bench for sqrt_magnitude_feeder with a small behavioural root unit.
// Latency: root model raises DONE LAT cycles after it sees START.
// Backpressure: consumer ready is driven per scenario.
module tb_sqrt_magnitude_feeder;
    localparam int LAT = 3;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = 16'd0;
    logic [15:0] in_y = 16'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_mag;
    logic        out_err;
    logic        sq_start;
    logic [31:0] sq_in;
    logic        busy;
    logic        sq_done = 1'b0;
    logic        sq_available = 1'b1;
    logic [31:0] sq_out = 32'd0;

    int checks = 0;
    int failures = 0;

    logic        model_hang = 1'b0;
    logic [31:0] model_result = 32'd0;
    logic [31:0] seen_in = 32'd0;
    int          starts = 0;
    int          mstate = 0;
    int          mcnt = 0;
    logic        start_q = 1'b0;

    always #5 clk = ~clk;

    sqrt_magnitude_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag), .out_err(out_err),
        .sq_start(sq_start), .sq_in(sq_in), .sq_done(sq_done),
        .sq_available(sq_available), .sq_out(sq_out), .busy(busy)
    );

    // Behavioural root unit: START -> LAT cycles -> DONE held until START drops
    always @(posedge clk) begin
        start_q <= sq_start;
        if (sq_start && !start_q) starts <= starts + 1;
        case (mstate)
            0: if (sq_start) begin
                sq_available <= 1'b0;
                mcnt         <= 0;
                seen_in      <= sq_in;
                mstate       <= 1;
            end
            1: if (!sq_start) begin
                sq_available <= 1'b1;
                mstate       <= 0;
            end else if (!model_hang) begin
                if (mcnt == LAT - 1) begin
                    sq_done <= 1'b1;
                    sq_out  <= model_result;
                    mstate  <= 2;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
            2: if (!sq_start) begin
                sq_done      <= 1'b0;
                sq_available <= 1'b1;
                sq_out       <= 32'd0;
                mstate       <= 0;
            end
            default: mstate <= 0;
        endcase
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // n = clock edges after the accept edge until out_valid; hi = cycles with sq_start high
    task automatic wait_out(output int n, output int hi);
        n = 0;
        hi = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (sq_start === 1'b1) hi++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if ({out_valid, out_err, sq_start, busy} !== 4'b0000 || out_mag !== 32'd0 || sq_in !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b err=%b start=%b busy=%b mag=%h sq_in=%h exp all 0",
                     out_valid, out_err, sq_start, busy, out_mag, sq_in);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        int n, hi, s0;
        s0 = starts;
        model_result = 32'h0005_0000;
        send(16'd3, 16'd4);
        wait_out(n, hi);
        checks++; if (n !== 40) begin failures++; $display("FAIL basic_latency got=%0d exp=40", n); end
        checks++; if (seen_in !== 32'd25) begin failures++; $display("FAIL basic_sq_in got=%h exp=00000019", seen_in); end
        checks++; if (starts - s0 !== 1) begin failures++; $display("FAIL basic_start_pulses got=%0d exp=1", starts - s0); end
        checks++; if (out_mag !== 32'h0005_0000 || out_err !== 1'b0) begin
            failures++; $display("FAIL basic_result got mag=%h err=%b exp mag=00050000 err=0", out_mag, out_err); end
        consume();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_release got valid=%b busy=%b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_max();
        int n, hi;
        model_result = 32'hB504_F334;
        send(16'h8000, 16'h8000);
        wait_out(n, hi);
        checks++; if (seen_in !== 32'h8000_0000) begin failures++; $display("FAIL max_sq_in got=%h exp=80000000", seen_in); end
        checks++; if (out_mag !== 32'hB504_F334 || out_err !== 1'b0) begin
            failures++; $display("FAIL max_result got mag=%h err=%b exp mag=b504f334 err=0", out_mag, out_err); end
        consume();
    endtask

    task automatic test_zero();
        int n, hi, s0;
        s0 = starts;
        model_result = 32'hDEAD_BEEF;
        send(16'd0, 16'd0);
        wait_out(n, hi);
        checks++; if (n !== 33) begin failures++; $display("FAIL zero_latency got=%0d exp=33", n); end
        checks++; if (hi !== 0 || starts - s0 !== 0) begin
            failures++; $display("FAIL zero_no_start got high_cycles=%0d pulses=%0d exp 0 0", hi, starts - s0); end
        checks++; if (out_mag !== 32'd0 || out_err !== 1'b0) begin
            failures++; $display("FAIL zero_result got mag=%h err=%b exp 0 0", out_mag, out_err); end
        consume();
    endtask

    task automatic test_backpressure();
        int n, hi;
        model_result = 32'h000A_0000;
        send(16'd6, 16'd8);
        wait_out(n, hi);
        checks++; if (seen_in !== 32'd100) begin failures++; $display("FAIL bp_sq_in got=%h exp=00000064", seen_in); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_mag !== 32'h000A_0000 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b mag=%h in_ready=%b exp 1 000a0000 0",
                         i, out_valid, out_mag, in_ready);
            end
            @(negedge clk);
        end
        consume();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_timeout();
        int n, hi;
        model_hang = 1'b1;
        send(16'd1, 16'd1);
        wait_out(n, hi);
        checks++; if (hi !== TMO) begin failures++; $display("FAIL timeout_start_cycles got=%0d exp=%0d", hi, TMO); end
        checks++; if (out_err !== 1'b1 || out_mag !== 32'd0) begin
            failures++; $display("FAIL timeout_result got err=%b mag=%h exp err=1 mag=0", out_err, out_mag); end
        consume();
        model_hang = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int n, hi, w;
        model_hang = 1'b1;
        send(16'd2, 16'd2);
        w = 0;
        while (sq_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        checks++; if (sq_start !== 1'b1) begin failures++; $display("FAIL midreset_reach_req got start=%b exp=1", sq_start); end
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        checks++; if (sq_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_cycle got start=%b valid=%b in_ready=%b exp 0 0 0", sq_start, out_valid, in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        model_hang = 1'b0;
        model_result = 32'h000D_0000;
        send(16'd5, 16'd12);
        wait_out(n, hi);
        checks++; if (seen_in !== 32'd169) begin failures++; $display("FAIL midreset_sq_in got=%h exp=000000a9", seen_in); end
        checks++; if (out_mag !== 32'h000D_0000 || out_err !== 1'b0) begin
            failures++; $display("FAIL midreset_result got mag=%h err=%b exp 000d0000 0", out_mag, out_err); end
        consume();
    endtask

    task automatic test_back_to_back();
        int n, hi;
        model_result = 32'h0005_0000;
        send(16'hFFFD, 16'hFFFC);
        wait_out(n, hi);
        checks++; if (seen_in !== 32'd25 || out_mag !== 32'h0005_0000) begin
            failures++; $display("FAIL b2b_first got sq_in=%h mag=%h exp 00000019 00050000", seen_in, out_mag); end
        consume();
        model_result = 32'h0011_0000;
        send(16'd8, 16'hFFF1);
        wait_out(n, hi);
        checks++; if (seen_in !== 32'd289 || out_mag !== 32'h0011_0000) begin
            failures++; $display("FAIL b2b_second got sq_in=%h mag=%h exp 00000121 00110000", seen_in, out_mag); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
